adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `LEN_DATA`-bit prefix adder between `NREQ` requesters. It presents the granted requester's operands to the adder and applies the subtract inversion and carry-in. It captures the sum and carry-out in a single response register, tagged with the requester index. It sits between the execute-stage clients (ALU, address generation, and similar) and the prefix adder datapath.

---
 rtl/adder_arbiter.sv | 144 ++++++++++++++
 tb/tb_adder_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one combinational prefix adder between NREQ requesters.
// Optional multi-word lock chains are enabled with `define ADDER_ARB_LOCK_EN.
module adder_arbiter #(
  parameter int NREQ     = 2,
  parameter int IDW      = 1,
  parameter int LEN_DATA = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*LEN_DATA-1:0] req_a,
  input  logic [NREQ*LEN_DATA-1:0] req_b,
  input  logic [NREQ-1:0]          req_sub,
`ifdef ADDER_ARB_LOCK_EN
  input  logic [NREQ-1:0]          req_lock,
`endif
  output logic [LEN_DATA-1:0]      add_a,
  output logic [LEN_DATA-1:0]      add_b,
  output logic                     add_cin,
  input  logic [LEN_DATA-1:0]      add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [LEN_DATA-1:0]      rsp_sum,
  output logic                     rsp_cout
);

`ifdef ADDER_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t         state;
  logic [IDW-1:0] chain_id;
  logic           chain_c;
`endif

  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      grant_idx;
  logic [IDW-1:0]      scan_idx;
  logic                grant_vld;
  logic                slot_free;
  logic                accept;
  logic [LEN_DATA-1:0] op_a [NREQ];
  logic [LEN_DATA-1:0] op_b [NREQ];

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + IDW'(1);
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_a[gi] = req_a[gi*LEN_DATA +: LEN_DATA];
    assign op_b[gi] = req_b[gi*LEN_DATA +: LEN_DATA];
  end

  // Circular scan from ptr; an open chain pins the grant to its owner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(ptr) + k) % NREQ);
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
`ifdef ADDER_ARB_LOCK_EN
    if (state == LOCKED) begin
      grant_vld = 1'b1;
      grant_idx = chain_id;
    end
`endif
  end

  assign slot_free = ~rsp_valid | rsp_ready;
  assign accept    = grant_vld & slot_free & req_valid[grant_idx];

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (grant_vld) begin
      if (slot_free) req_ready[grant_idx] = 1'b1;
      add_a   = op_a[grant_idx];
      add_b   = req_sub[grant_idx] ? ~op_b[grant_idx] : op_b[grant_idx];
      add_cin = req_sub[grant_idx];
`ifdef ADDER_ARB_LOCK_EN
      if (state == LOCKED) add_cin = chain_c;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
      ptr       <= '0;
`ifdef ADDER_ARB_LOCK_EN
      state     <= ARB;
      chain_id  <= '0;
      chain_c   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_id    <= grant_idx;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
`ifdef ADDER_ARB_LOCK_EN
      case (state)
        ARB: begin
          if (accept) begin
            ptr <= wrap_inc(grant_idx);
            if (req_lock[grant_idx]) begin
              state    <= LOCKED;
              chain_id <= grant_idx;
              chain_c  <= add_cout;
            end
          end
        end
        LOCKED: begin
          if (accept) begin
            chain_c <= add_cout;
            if (!req_lock[grant_idx]) begin
              state <= ARB;
              ptr   <= wrap_inc(chain_id);
            end
          end
        end
        default: state <= ARB;
      endcase
`else
      if (accept) ptr <= wrap_inc(grant_idx);
`endif
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (NREQ=2, LEN_DATA=32); lock-chain steps
// are included when ADDER_ARB_LOCK_EN is defined.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_sub;
  logic [1:0]  req_lock;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_sum;
  logic        rsp_cout;

  int errors = 0;
  int checks = 0;

  // Reference state: what the response register and rotation pointer should hold
  int          mPtr;
  bit          mValid;
  logic [31:0] mSum;
  logic        mCout;
  int          mId;

  always #5 clk = ~clk;

  // The shared prefix adder, modelled as plain arithmetic
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  adder_arbiter #(.NREQ(2), .IDW(1), .LEN_DATA(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
`ifdef ADDER_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] sub,
                               input logic [1:0] lock, input logic rr);
    req_valid = valid;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_sub   = sub;
    req_lock  = lock;
    rsp_ready = rr;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0);
    tick();
    tick();
    rst    = 1'b0;
    mPtr   = 0;
    mValid = 1'b0;
    mSum   = '0;
    mCout  = 1'b0;
    mId    = 0;
  endtask

  // One clock of the reference model: rotating priority, single-slot response buffer
  task automatic stepCycle(input string tag);
    int          g;
    int          idx;
    bit          slot;
    logic [1:0]  expReady;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] wide;
    bit          nValid;
    #1;
    g = -1;
    for (int k = 0; k < 2; k++) begin
      idx = (mPtr + k) % 2;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    slot     = !mValid || rsp_ready;
    expReady = (g >= 0 && slot) ? (2'b01 << g) : 2'b00;
    checkOutput({tag, "_ready"}, {62'd0, req_ready}, {62'd0, expReady});
    nValid = mValid && !rsp_ready;
    if (g >= 0 && slot) begin
      a      = req_a[g*32 +: 32];
      b      = req_b[g*32 +: 32];
      wide   = {1'b0, a} + {1'b0, b};
      mSum   = req_sub[g] ? a - b : a + b;
      mCout  = req_sub[g] ? (a >= b) : wide[32];
      mId    = g;
      mPtr   = (g + 1) % 2;
      nValid = 1'b1;
    end
    mValid = nValid;
    tick();
    checkOutput({tag, "_rvalid"}, {63'd0, rsp_valid}, {63'd0, mValid});
    if (mValid) begin
      checkOutput({tag, "_rid"}, {63'd0, rsp_id}, mId);
      checkOutput({tag, "_rsum"}, {32'd0, rsp_sum}, {32'd0, mSum});
      checkOutput({tag, "_rcout"}, {63'd0, rsp_cout}, {63'd0, mCout});
    end
  endtask

  initial begin
    doReset();
    checkOutput("reset_valid", {63'd0, rsp_valid}, 0);
    checkOutput("reset_sum", {32'd0, rsp_sum}, 0);
    checkOutput("reset_cout", {63'd0, rsp_cout}, 0);
    checkOutput("reset_id", {63'd0, rsp_id}, 0);

    // Single add from requester 0
    applyStimulus(2'b01, 32'h5, 32'h3, 0, 0, 2'b00, 2'b00, 1'b1);
    stepCycle("add");
    checkOutput("add_sum_const", {32'd0, rsp_sum}, 64'h8);
    checkOutput("add_id_const", {63'd0, rsp_id}, 0);

    // Subtract wrap and exact zero from requester 1
    applyStimulus(2'b10, 0, 0, 32'h0, 32'h1, 2'b10, 2'b00, 1'b1);
    #1;
    checkOutput("sub_add_b", {32'd0, add_b}, 64'hFFFF_FFFE);
    checkOutput("sub_add_cin", {63'd0, add_cin}, 1);
    stepCycle("subwrap");
    checkOutput("subwrap_const", {32'd0, rsp_sum}, 64'hFFFF_FFFF);
    checkOutput("subwrap_cout", {63'd0, rsp_cout}, 0);
    applyStimulus(2'b10, 0, 0, 32'h5, 32'h5, 2'b10, 2'b00, 1'b1);
    stepCycle("subzero");
    checkOutput("subzero_cout", {63'd0, rsp_cout}, 1);
    applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1'b1);
    #1;
    checkOutput("idle_add_a", {32'd0, add_a}, 0);
    stepCycle("drain");

    // Fairness from reset: both requesters continuously valid
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 32'd10 + i, 32'd1, 32'd100 + i, 32'd2, 2'b00, 2'b00, 1'b1);
      #1;
      checkOutput("rr_order", {62'd0, req_ready}, (i % 2 == 0) ? 64'h1 : 64'h2);
      stepCycle("rr");
      checkOutput("rr_id", {63'd0, rsp_id}, i % 2);
    end

    // Backpressure: hold, then drain and accept in the same cycle
    doReset();
    applyStimulus(2'b01, 32'h11, 32'h22, 0, 0, 2'b00, 2'b00, 1'b1);
    stepCycle("bp_load");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 32'h7, 32'h8, 0, 0, 2'b00, 2'b00, 1'b0);
      stepCycle("bp_hold");
      checkOutput("bp_held_sum", {32'd0, rsp_sum}, 64'h33);
    end
    applyStimulus(2'b01, 32'h7, 32'h8, 0, 0, 2'b00, 2'b00, 1'b1);
    stepCycle("bp_release");
    checkOutput("bp_reload_sum", {32'd0, rsp_sum}, 64'hF);

    // Reset discards a pending response
    applyStimulus(2'b10, 0, 0, 32'h1, 32'h1, 2'b00, 2'b00, 1'b0);
    stepCycle("pre_rst");
    doReset();
    checkOutput("midrst_valid", {63'd0, rsp_valid}, 0);

`ifdef ADDER_ARB_LOCK_EN
    // Two-word chain from requester 0 while requester 1 waits
    doReset();
    applyStimulus(2'b11, 32'hFFFF_FFFF, 32'h1, 32'h9, 32'h9, 2'b00, 2'b01, 1'b1);
    #1;
    checkOutput("lk0_ready", {62'd0, req_ready}, 1);
    tick();
    checkOutput("lk0_sum", {32'd0, rsp_sum}, 0);
    checkOutput("lk0_cout", {63'd0, rsp_cout}, 1);
    applyStimulus(2'b10, 0, 0, 32'h9, 32'h9, 2'b00, 2'b01, 1'b1);
    #1;
    checkOutput("lk_idle_ready", {62'd0, req_ready}, 1);
    tick();
    checkOutput("lk_idle_valid", {63'd0, rsp_valid}, 0);
    applyStimulus(2'b11, 0, 0, 32'h9, 32'h9, 2'b00, 2'b00, 1'b1);
    #1;
    checkOutput("lk1_ready", {62'd0, req_ready}, 1);
    checkOutput("lk1_cin", {63'd0, add_cin}, 1);
    tick();
    checkOutput("lk1_sum", {32'd0, rsp_sum}, 1);
    checkOutput("lk1_cout", {63'd0, rsp_cout}, 0);
    checkOutput("lk1_id", {63'd0, rsp_id}, 0);
    applyStimulus(2'b11, 0, 0, 32'h9, 32'h9, 2'b00, 2'b00, 1'b1);
    #1;
    checkOutput("lk_after_ready", {62'd0, req_ready}, 2);
    tick();
    checkOutput("lk_after_id", {63'd0, rsp_id}, 1);

    // Reset while a chain is open
    doReset();
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h1, 0, 0, 2'b00, 2'b01, 1'b1);
    tick();
    checkOutput("lkrst_pre_valid", {63'd0, rsp_valid}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("lkrst_valid", {63'd0, rsp_valid}, 0);
    applyStimulus(2'b11, 32'h5, 32'h3, 32'h9, 32'h9, 2'b00, 2'b00, 1'b1);
    #1;
    checkOutput("lkrst_ready", {62'd0, req_ready}, 1);
    checkOutput("lkrst_cin", {63'd0, add_cin}, 0);
    tick();
    checkOutput("lkrst_sum", {32'd0, rsp_sum}, 8);
`endif

    // Randomized traffic against the reference model
    doReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                    2'($urandom_range(0, 3)), 2'b00, ($urandom_range(0, 3) != 0));
      stepCycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
